// File: rtl/nrf_spi_responder.sv
// SPI mode-0 slave answering nRF24L01-style R_REGISTER / W_REGISTER / NOP commands
// from an internal register file; STATUS is returned during every command byte.
module nrf_spi_responder #(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_csn,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] status_in,
  input  logic [4:0] host_rd_addr,
  output logic [7:0] host_rd_data,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       wr_strobe,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_abort
);

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned REG_SLOTS = 32;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_IGN  = 3'd4;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  function automatic logic [DATA_W-1:0] reset_value(input int unsigned i);
    case (i)
      0:       return 8'h08;
      1:       return 8'h3F;
      2:       return 8'h03;
      3:       return 8'h03;
      4:       return 8'h03;
      5:       return 8'h02;
      6:       return 8'h0E;
      default: return 8'h00;
    endcase
  endfunction

  // Input synchronizers and edge detection on the synced copies
  logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
  logic sck_prev, csn_prev;
  logic sck_s, csn_s, mosi_s;
  logic sck_rise, sck_fall, csn_rise, csn_fall;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign csn_s    = csn_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign csn_rise = csn_s & ~csn_prev;
  assign csn_fall = ~csn_s & csn_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync  <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      csn_prev  <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_prev  <= sck_s;
      csn_prev  <= csn_s;
    end
  end

  logic [2:0]        state, state_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [6:0]        rx_sr, rx_sr_n;
  logic [6:0]        tx_sr, tx_sr_n;
  logic [DATA_W-1:0] tx_next, tx_next_n;
  logic              at_bound, at_bound_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              miso_n, oe_n;
  logic              cmd_valid_n, wr_strobe_n, frame_abort_n;
  logic [DATA_W-1:0] cmd_byte_n, wr_data_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic              reg_we;
  logic [DATA_W-1:0] rx_full;
  logic [DATA_W-1:0] regs [REG_SLOTS];

  function automatic logic [DATA_W-1:0] rd_reg(input logic [ADDR_W-1:0] a);
    return in_range(a) ? regs[a] : 8'h00;
  endfunction

  assign rx_full      = {rx_sr, mosi_s};
  assign host_rd_data = rd_reg(host_rd_addr);

  // Frame FSM plus shift datapath next-state
  always_comb begin
    state_n       = state;
    bit_cnt_n     = bit_cnt;
    rx_sr_n       = rx_sr;
    tx_sr_n       = tx_sr;
    tx_next_n     = tx_next;
    at_bound_n    = at_bound;
    addr_n        = addr;
    miso_n        = spi_miso;
    oe_n          = spi_miso_oe;
    cmd_valid_n   = 1'b0;
    cmd_byte_n    = cmd_byte;
    wr_strobe_n   = 1'b0;
    wr_addr_n     = wr_addr;
    wr_data_n     = wr_data;
    frame_abort_n = 1'b0;
    reg_we        = 1'b0;

    if (state == ST_IDLE) begin
      if (csn_fall) begin
        state_n    = ST_CMD;
        tx_sr_n    = status_in[6:0];
        miso_n     = status_in[7];
        oe_n       = 1'b1;
        bit_cnt_n  = 3'd0;
        at_bound_n = 1'b0;
      end
    end else if (csn_rise) begin
      state_n       = ST_IDLE;
      miso_n        = 1'b0;
      oe_n          = 1'b0;
      frame_abort_n = (bit_cnt != 3'd0);
      bit_cnt_n     = 3'd0;
      at_bound_n    = 1'b0;
    end else if (sck_rise) begin
      rx_sr_n   = rx_full[6:0];
      bit_cnt_n = bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        at_bound_n = 1'b1;
        case (state)
          ST_CMD: begin
            cmd_valid_n = 1'b1;
            cmd_byte_n  = rx_full;
            addr_n      = rx_full[4:0];
            if (rx_full[7:5] == 3'b000) begin
              state_n   = ST_RD;
              tx_next_n = rd_reg(rx_full[4:0]);
            end else if (rx_full[7:5] == 3'b001) begin
              state_n   = ST_WR;
              tx_next_n = 8'h00;
            end else begin
              state_n   = ST_IGN;
              tx_next_n = 8'h00;
            end
          end
          ST_RD: tx_next_n = rd_reg(addr);
          ST_WR: begin
            reg_we      = 1'b1;
            wr_strobe_n = 1'b1;
            wr_addr_n   = addr;
            wr_data_n   = rx_full;
            tx_next_n   = 8'h00;
          end
          default: tx_next_n = 8'h00;
        endcase
      end
    end else if (sck_fall) begin
      // First fall after a byte boundary presents the next byte's MSB
      if (at_bound) begin
        tx_sr_n    = tx_next[6:0];
        miso_n     = tx_next[7];
        at_bound_n = 1'b0;
      end else begin
        tx_sr_n = {tx_sr[5:0], 1'b0};
        miso_n  = tx_sr[6];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= 3'd0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      tx_next     <= '0;
      at_bound    <= 1'b0;
      addr        <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_byte    <= '0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      rx_sr       <= rx_sr_n;
      tx_sr       <= tx_sr_n;
      tx_next     <= tx_next_n;
      at_bound    <= at_bound_n;
      addr        <= addr_n;
      spi_miso    <= miso_n;
      spi_miso_oe <= oe_n;
      cmd_valid   <= cmd_valid_n;
      cmd_byte    <= cmd_byte_n;
      wr_strobe   <= wr_strobe_n;
      wr_addr     <= wr_addr_n;
      wr_data     <= wr_data_n;
      frame_abort <= frame_abort_n;
    end
  end

  // Register file; slots at or above NUM_REGS are never written or read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < REG_SLOTS; i++) regs[i] <= reset_value(i);
    end else if (reg_we && in_range(wr_addr_n)) begin
      regs[wr_addr_n] <= wr_data_n;
    end
  end

endmodule
